// File: rtl/ad_ip_jesd204_tpl_dac_sel_sched_if.sv
// Config/trigger side and channel-datapath side of the DAC data-source scheduler.
// The scheduler connects through the slave modport; the register bank drives the master side.
interface ad_ip_jesd204_tpl_dac_sel_sched_if #(
  parameter int NUM_CHANNELS = 2
);
  logic [4*NUM_CHANNELS-1:0] cfg_data_sel;
  logic [NUM_CHANNELS-1:0]   cfg_mask_enable;
  logic                      cfg_update;
  logic                      cfg_abort;
  logic [1:0]                cfg_trig_mode;
  logic [15:0]               cfg_holdoff;
  logic                      cfg_status_clr;
  logic                      ext_sync;
  logic [4*NUM_CHANNELS-1:0] dac_data_sel;
  logic [NUM_CHANNELS-1:0]   dac_mask_enable;
  logic                      dac_data_sync;
  logic                      status_busy;
  logic [7:0]                status_update_count;
  logic                      status_missed;

  modport master (
    output cfg_data_sel, cfg_mask_enable, cfg_update, cfg_abort, cfg_trig_mode,
           cfg_holdoff, cfg_status_clr, ext_sync,
    input  dac_data_sel, dac_mask_enable, dac_data_sync, status_busy,
           status_update_count, status_missed
  );

  modport slave (
    input  cfg_data_sel, cfg_mask_enable, cfg_update, cfg_abort, cfg_trig_mode,
           cfg_holdoff, cfg_status_clr, ext_sync,
    output dac_data_sel, dac_mask_enable, dac_data_sync, status_busy,
           status_update_count, status_missed
  );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_sel_sched.sv
// Atomic data_sel/mask_enable switch for all DAC channels after a trigger and optional mute.
// Latency 2+M cycles (mode 0) or 2+H+M (holdoff); no backpressure, late requests flag status_missed.
module ad_ip_jesd204_tpl_dac_sel_sched #(
  parameter int NUM_CHANNELS = 2,
  parameter int MUTE_CYCLES  = 4
) (
  input logic                         clk,
  input logic                         resetn,
  ad_ip_jesd204_tpl_dac_sel_sched_if.slave bus
);
  localparam int SW = 4 * NUM_CHANNELS;
  localparam int MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
  localparam logic [MW-1:0] MUTE_LOAD = (MUTE_CYCLES > 0) ? MW'(MUTE_CYCLES - 1) : '0;
  localparam logic [SW-1:0] MUTE_SEL  = {NUM_CHANNELS{4'h3}};

  typedef enum logic [1:0] {IDLE, ARMED, MUTE, APPLY} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           shadow_sel_q, shadow_sel_d;
  logic [NUM_CHANNELS-1:0] shadow_mask_q, shadow_mask_d;
  logic [SW-1:0]           active_sel_q, active_sel_d;
  logic [NUM_CHANNELS-1:0] active_mask_q, active_mask_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [1:0]              mode_q, mode_d;
  logic [15:0]             hold_q, hold_d;
  logic [MW-1:0]           mute_cnt_q, mute_cnt_d;
  logic [7:0]              count_q, count_d;
  logic                    ext_sync_q, ext_sync_d;
  logic                    sync_q, sync_d;
  logic                    missed_q, missed_d;
  logic                    busy_q, busy_d;
  logic                    upd, trig, apply_now, missed_evt;

  always_comb begin
    state_d       = state_q;
    shadow_sel_d  = shadow_sel_q;
    shadow_mask_d = shadow_mask_q;
    active_sel_d  = active_sel_q;
    active_mask_d = active_mask_q;
    sel_d         = sel_q;
    mask_d        = mask_q;
    mode_d        = mode_q;
    hold_d        = hold_q;
    mute_cnt_d    = mute_cnt_q;
    count_d       = count_q;
    ext_sync_d    = bus.ext_sync;
    sync_d        = 1'b0;
    apply_now     = 1'b0;
    missed_evt    = 1'b0;
    // Abort wins over a same-cycle update everywhere, so that update never counts as missed.
    upd           = bus.cfg_update & ~bus.cfg_abort;

    trig = 1'b1;
    case (mode_q)
      2'd1:    trig = bus.ext_sync & ~ext_sync_q;
      2'd2:    trig = (hold_q == 16'd0);
      default: trig = 1'b1;
    endcase

    case (state_q)
      IDLE: begin
        if (upd) begin
          shadow_sel_d  = bus.cfg_data_sel;
          shadow_mask_d = bus.cfg_mask_enable;
          mode_d        = bus.cfg_trig_mode;
          hold_d        = bus.cfg_holdoff;
          state_d       = ARMED;
        end
      end
      ARMED: begin
        if (bus.cfg_abort) begin
          state_d = IDLE;
          sel_d   = active_sel_q;
          mask_d  = active_mask_q;
        end else if (upd) begin
          shadow_sel_d  = bus.cfg_data_sel;
          shadow_mask_d = bus.cfg_mask_enable;
          mode_d        = bus.cfg_trig_mode;
          hold_d        = bus.cfg_holdoff;
          missed_evt    = 1'b1;
        end else if (trig) begin
          if (MUTE_CYCLES > 0) begin
            state_d    = MUTE;
            sel_d      = MUTE_SEL;
            mask_d     = '0;
            mute_cnt_d = MUTE_LOAD;
          end else begin
            apply_now = 1'b1;
          end
        end else if (mode_q == 2'd2) begin
          hold_d = hold_q - 16'd1;
        end
      end
      MUTE: begin
        if (bus.cfg_abort) begin
          state_d = IDLE;
          sel_d   = active_sel_q;
          mask_d  = active_mask_q;
        end else begin
          missed_evt = upd;
          if (mute_cnt_q == '0) apply_now = 1'b1;
          else                  mute_cnt_d = mute_cnt_q - MW'(1);
        end
      end
      APPLY: begin
        missed_evt = upd;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (apply_now) begin
      state_d       = APPLY;
      sel_d         = shadow_sel_q;
      mask_d        = shadow_mask_q;
      active_sel_d  = shadow_sel_q;
      active_mask_d = shadow_mask_q;
      sync_d        = 1'b1;
      count_d       = count_q + 8'd1;
    end

    missed_d = (missed_q & ~bus.cfg_status_clr) | missed_evt;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      shadow_sel_q  <= '0;
      shadow_mask_q <= '0;
      active_sel_q  <= '0;
      active_mask_q <= '0;
      sel_q         <= '0;
      mask_q        <= '0;
      mode_q        <= 2'd0;
      hold_q        <= 16'd0;
      mute_cnt_q    <= '0;
      count_q       <= 8'd0;
      ext_sync_q    <= 1'b0;
      sync_q        <= 1'b0;
      missed_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_sel_q  <= shadow_sel_d;
      shadow_mask_q <= shadow_mask_d;
      active_sel_q  <= active_sel_d;
      active_mask_q <= active_mask_d;
      sel_q         <= sel_d;
      mask_q        <= mask_d;
      mode_q        <= mode_d;
      hold_q        <= hold_d;
      mute_cnt_q    <= mute_cnt_d;
      count_q       <= count_d;
      ext_sync_q    <= ext_sync_d;
      sync_q        <= sync_d;
      missed_q      <= missed_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.dac_data_sel        = sel_q;
  assign bus.dac_mask_enable     = mask_q;
  assign bus.dac_data_sync       = sync_q;
  assign bus.status_busy         = busy_q;
  assign bus.status_update_count = count_q;
  assign bus.status_missed       = missed_q;
endmodule
